// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache that sits between
// the fetch stage and instruction memory. Hits return data combinationally;
// misses fill a whole line from memory and then pulse i_ready for one cycle.
// Define ICACHE_STATS_EN to build saturating hit/miss counters; without it
// the counter ports are tied to zero.
module instr_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_readC,
  input  logic [WORD_SIZE-1:0]            i_address,
  output logic [WORD_SIZE-1:0]            i_data,
  output logic                            i_cache_hit,
  output logic                            i_ready,
  output logic                            i_mem_read,
  output logic [WORD_SIZE-1:0]            i_mem_addr,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] i_mem_data,
  input  logic                            i_mem_ack,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
  typedef logic [LINE_WORDS-1:0][WORD_SIZE-1:0] line_t;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] miss_addr_q, miss_addr_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  logic [OFF_W-1:0] req_off, miss_off;
  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             lookup_hit;
  logic             fill_en;

  assign req_off  = i_address[OFF_W-1:0];
  assign req_idx  = i_address[OFF_W +: IDX_W];
  assign req_tag  = i_address[WORD_SIZE-1 -: TAG_W];
  assign miss_off = miss_addr_q[OFF_W-1:0];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag = miss_addr_q[WORD_SIZE-1 -: TAG_W];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_en    = (state_q == FILL) && i_mem_ack;

  // Next-state and output decode; outputs default to the idle/no-request view.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    i_data      = '0;
    i_cache_hit = 1'b1;
    i_ready     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_addr  = '0;
    case (state_q)
      IDLE: begin
        i_cache_hit = !i_readC || lookup_hit;
        if (i_readC && lookup_hit) begin
          i_data = data_q[req_idx][req_off];
        end else if (i_readC) begin
          miss_addr_d = i_address;
          state_d     = FILL;
        end
      end
      FILL: begin
        i_cache_hit = 1'b0;
        i_mem_read  = 1'b1;
        i_mem_addr  = {miss_addr_q[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        if (i_mem_ack) begin
          state_d = DONE;
        end
      end
      DONE: begin
        i_ready = 1'b1;
        i_data  = data_q[miss_idx][miss_off];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched miss address and valid bits; reset invalidates every line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and line storage, written only when a fill is acknowledged.
  always_ff @(posedge clk) begin
    if (!reset && fill_en) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= i_mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating counters: served requests in IDLE, and IDLE-to-FILL transitions.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && i_readC && lookup_hit && hit_count_q != 16'hFFFF) begin
      hit_count_d = hit_count_q + 16'd1;
    end
    if (state_q == IDLE && i_readC && !lookup_hit && miss_count_q != 16'hFFFF) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: self-checking bench for instr_cache. A behavioural model
// tracks which memory line each cache set holds and predicts outputs from a
// bench-owned memory image; directed scenarios pin the model with literals,
// then randomized traffic runs against it. Honors ICACHE_STATS_EN.
module tb_instr_cache;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        i_readC;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_cache_hit;
  logic        i_ready;
  logic        i_mem_read;
  logic [15:0] i_mem_addr;
  logic [63:0] i_mem_data;
  logic        i_mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  instr_cache dut (
    .clk(clk), .reset(reset), .i_readC(i_readC), .i_address(i_address),
    .i_data(i_data), .i_cache_hit(i_cache_hit), .i_ready(i_ready),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .i_mem_ack(i_mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image backing the cache.
  logic [15:0] mem [65536];

  // Memory responder controls: ackDelay < 0 picks a random delay per fill.
  int ackDelay  = 0;
  bit randomAck = 1'b0;
  bit fillSeen  = 1'b0;
  int waitLeft  = -1;

  // Model state: which line address each set holds (-1 = invalid).
  int          lineAt [4];
  bit          modelKnown = 1'b0;
  bit          fillPending;
  bit          deliverPending;
  logic [15:0] missAddr;
  int          hitCnt;
  int          missCnt;
  int          mIdx;
  bit          mCached;

  function automatic logic [63:0] lineData(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    return {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rc, input logic [15:0] a);
    @(posedge clk);
    #1;
    reset     = rst;
    i_readC   = rc;
    i_address = a;
    @(negedge clk);
  endtask

  task automatic waitReady(input string name, input int maxCycles, output int cycles);
    cycles = 0;
    for (int k = 1; k <= maxCycles; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (i_ready === 1'b1) begin
        cycles = k;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s: no i_ready within %0d cycles", name, maxCycles);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) lineAt[i] = -1;
    fillPending    = 1'b0;
    deliverPending = 1'b0;
    missAddr       = '0;
    hitCnt         = 0;
    missCnt        = 0;
  endfunction

  // Memory responder: acks each fill after the chosen delay, optionally
  // sprinkling stray acks with junk data while no fill is outstanding.
  always begin
    @(posedge clk);
    #1;
    if (i_mem_read === 1'b1) begin
      if (!fillSeen) begin
        fillSeen = 1'b1;
        waitLeft = (ackDelay < 0) ? int'($urandom_range(0, 3)) : ackDelay;
      end
      if (waitLeft == 0) begin
        i_mem_ack  = 1'b1;
        i_mem_data = lineData(i_mem_addr);
        waitLeft   = -1;
      end else begin
        i_mem_ack = 1'b0;
        if (waitLeft > 0) waitLeft--;
      end
    end else begin
      fillSeen   = 1'b0;
      i_mem_ack  = randomAck && ($urandom_range(0, 7) == 0);
      i_mem_data = {$urandom, $urandom};
    end
  end

  // Compare process: predict every meaningful output, then advance the model
  // with the inputs the next rising edge will sample.
  always @(negedge clk) begin
    if (!modelKnown) begin
      if (reset) begin
        modelReset();
        modelKnown = 1'b1;
      end
    end else begin
      mIdx    = int'(i_address[3:2]);
      mCached = (lineAt[mIdx] == int'(i_address[15:2]));
      if (deliverPending) begin
        checkOutput("model_done_hit", i_cache_hit, 1);
        checkOutput("model_done_ready", i_ready, 1);
        checkOutput("model_done_memread", i_mem_read, 0);
        checkOutput("model_done_data", i_data, mem[missAddr]);
      end else if (fillPending) begin
        checkOutput("model_fill_hit", i_cache_hit, 0);
        checkOutput("model_fill_ready", i_ready, 0);
        checkOutput("model_fill_memread", i_mem_read, 1);
        checkOutput("model_fill_memaddr", i_mem_addr, {missAddr[15:2], 2'b00});
      end else begin
        checkOutput("model_idle_hit", i_cache_hit, !i_readC || mCached);
        checkOutput("model_idle_ready", i_ready, 0);
        checkOutput("model_idle_memread", i_mem_read, 0);
        checkOutput("model_idle_data", i_data, (i_readC && mCached) ? mem[i_address] : 16'h0);
      end
      checkOutput("model_hit_count", hit_count, STATS ? hitCnt : 0);
      checkOutput("model_miss_count", miss_count, STATS ? missCnt : 0);

      if (reset) begin
        modelReset();
      end else if (deliverPending) begin
        deliverPending = 1'b0;
      end else if (fillPending) begin
        if (i_mem_ack) begin
          lineAt[int'(missAddr[3:2])] = int'(missAddr[15:2]);
          fillPending    = 1'b0;
          deliverPending = 1'b1;
        end
      end else if (i_readC) begin
        if (mCached) begin
          if (hitCnt < 65535) hitCnt++;
        end else begin
          missAddr    = i_address;
          fillPending = 1'b1;
          if (missCnt < 65535) missCnt++;
        end
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #1_200_000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int cyc;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 16'h9E37) ^ 16'h5A5A;
    mem[4] = 16'h000A;
    mem[5] = 16'h000B;
    mem[6] = 16'h000C;
    mem[7] = 16'h000D;

    reset      = 1'b1;
    i_readC    = 1'b0;
    i_address  = '0;
    i_mem_ack  = 1'b0;
    i_mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_hit", i_cache_hit, 1);
    checkOutput("rst_ready", i_ready, 0);
    checkOutput("rst_memread", i_mem_read, 0);
    checkOutput("rst_memaddr", i_mem_addr, 0);
    checkOutput("rst_data", i_data, 0);
    checkOutput("rst_hitcnt", hit_count, 0);
    checkOutput("rst_misscnt", miss_count, 0);

    $display("[TB] cold miss");
    ackDelay = 2;
    applyStimulus(0, 1, 16'h0005);
    checkOutput("cold_hit", i_cache_hit, 0);
    applyStimulus(0, 1, 16'h0005);
    checkOutput("cold_memaddr", i_mem_addr, 16'h0004);
    waitReady("cold_ready", 20, cyc);
    checkOutput("cold_latency", cyc, 3);
    checkOutput("cold_data", i_data, 16'h000B);
    checkOutput("cold_done_hit", i_cache_hit, 1);

    $display("[TB] warm hit");
    ackDelay = 0;
    applyStimulus(0, 1, 16'h0006);
    checkOutput("warm_hit", i_cache_hit, 1);
    checkOutput("warm_data", i_data, 16'h000C);
    checkOutput("warm_memread", i_mem_read, 0);
    checkOutput("warm_ready_once", i_ready, 0);

    $display("[TB] conflict misses");
    applyStimulus(0, 1, 16'h0014);
    checkOutput("conf1_hit", i_cache_hit, 0);
    checkOutput("stat_hitcnt", hit_count, STATS ? 1 : 0);
    checkOutput("stat_misscnt", miss_count, STATS ? 1 : 0);
    waitReady("conf1_ready", 20, cyc);
    checkOutput("conf1_latency", cyc, 2);
    checkOutput("conf1_data", i_data, mem[16'h0014]);
    applyStimulus(0, 1, 16'h0004);
    checkOutput("conf2_hit", i_cache_hit, 0);
    waitReady("conf2_ready", 20, cyc);
    checkOutput("conf2_data", i_data, 16'h000A);

    $display("[TB] address change during fill");
    applyStimulus(0, 1, 16'h0000);
    waitReady("pre_ready", 20, cyc);
    ackDelay = 1;
    applyStimulus(0, 1, 16'h0008);
    checkOutput("chg_miss", i_cache_hit, 0);
    applyStimulus(0, 1, 16'h0030);
    checkOutput("chg_memaddr", i_mem_addr, 16'h0008);
    waitReady("chg_ready", 20, cyc);
    checkOutput("chg_data", i_data, mem[16'h0008]);
    applyStimulus(0, 1, 16'h0000);
    checkOutput("chg_set0_hit", i_cache_hit, 1);
    checkOutput("chg_set0_data", i_data, mem[16'h0000]);
    applyStimulus(0, 1, 16'h0030);
    checkOutput("chg_0030_miss", i_cache_hit, 0);
    waitReady("chg2_ready", 20, cyc);

    $display("[TB] reset during fill");
    ackDelay = 6;
    applyStimulus(0, 1, 16'h0024);
    applyStimulus(0, 1, 16'h0024);
    applyStimulus(1, 1, 16'h0024);
    checkOutput("rstfill_memread_before", i_mem_read, 1);
    applyStimulus(0, 0, 16'h0024);
    checkOutput("rstfill_memread_after", i_mem_read, 0);
    checkOutput("rstfill_ready", i_ready, 0);
    applyStimulus(0, 0, 16'h0000);
    checkOutput("rstfill_ready2", i_ready, 0);
    ackDelay = 0;
    applyStimulus(0, 1, 16'h0005);
    checkOutput("rstfill_reread_miss", i_cache_hit, 0);
    waitReady("rstfill_ready3", 20, cyc);
    checkOutput("rstfill_reread_data", i_data, 16'h000B);

    $display("[TB] randomized traffic");
    ackDelay  = -1;
    randomAck = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, a);
    end
    randomAck = 1'b0;
    ackDelay  = 0;
    applyStimulus(0, 0, 16'h0000);
    applyStimulus(0, 0, 16'h0000);

`ifdef ICACHE_STATS_EN
    $display("[TB] hit counter saturation");
    applyStimulus(1, 0, 16'h0000);
    applyStimulus(0, 1, 16'h0000);
    waitReady("sat_fill", 20, cyc);
    for (int n = 0; n < 65540; n++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("sat_hitcnt", hit_count, 16'hFFFF);
    checkOutput("sat_misscnt", miss_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
